// File: rtl/h_cmd_queue.sv
// h_pkg: command payload types shared by the producer, this queue and engine h.
// h_cmd_queue: in-order FIFO in front of hash engine h that caps the number of
// issued-but-unanswered commands.
// Ports:
//   clk, arst_n               clock, asynchronous active-low reset
//   i_cmd_vld/opcode/k/v      producer command (push on i_cmd_vld && o_cmd_rdy)
//   o_cmd_rdy                 queue not full
//   o_cmd_vld_w/opcode/k/v_w  head command to h (pop on o_cmd_vld_w && i_cmd_rdy_w)
//   i_cmd_rdy_w               h accepts the command
//   i_rsp_vld                 h response pulse, retires one in-flight command
//   o_occupancy, o_outstanding, o_err  status; o_err is sticky until reset
package h_pkg;
  typedef logic [1:0]  opcode_t;
  typedef logic [7:0]  k_t;
  typedef logic [15:0] v_t;

  localparam opcode_t OP_NOP    = 2'd0;
  localparam opcode_t OP_INSERT = 2'd1;
  localparam opcode_t OP_LOOKUP = 2'd2;
  localparam opcode_t OP_DELETE = 2'd3;

  typedef struct packed {
    opcode_t opcode;
    k_t      k;
    v_t      v;
  } cmd_t;
endpackage

module h_cmd_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   arst_n,
  input  logic                                   i_cmd_vld,
  input  h_pkg::opcode_t                         i_cmd_opcode,
  input  h_pkg::k_t                              i_cmd_k,
  input  h_pkg::v_t                              i_cmd_v,
  output logic                                   o_cmd_rdy,
  output logic                                   o_cmd_vld_w,
  output h_pkg::opcode_t                         o_cmd_opcode_w,
  output h_pkg::k_t                              o_cmd_k_w,
  output h_pkg::v_t                              o_cmd_v_w,
  input  logic                                   i_cmd_rdy_w,
  input  logic                                   i_rsp_vld,
  output logic [$clog2(DEPTH+1)-1:0]             o_occupancy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_outstanding,
  output logic                                   o_err
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  h_pkg::cmd_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic [OUT_W-1:0] r_out;
  logic             r_err;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  h_pkg::cmd_t      w_wr;
  h_pkg::cmd_t      w_head;

  // Handshake qualifiers come from registered counts only, never from h's ready.
  assign w_empty     = (r_occ == '0);
  assign o_cmd_rdy   = (r_occ != OCC_W'(DEPTH));
  assign o_cmd_vld_w = !w_empty && (r_out < OUT_W'(MAX_OUTSTANDING));
  assign w_push      = i_cmd_vld && o_cmd_rdy;
  assign w_pop       = o_cmd_vld_w && i_cmd_rdy_w;

  assign w_wr = '{opcode: i_cmd_opcode, k: i_cmd_k, v: i_cmd_v};

  // Head entry; forced to zero when empty so stale storage never leaks out.
  assign w_head         = w_empty ? '0 : r_mem[r_rptr];
  assign o_cmd_opcode_w = w_head.opcode;
  assign o_cmd_k_w      = w_head.k;
  assign o_cmd_v_w      = w_head.v;

  assign o_occupancy   = r_occ;
  assign o_outstanding = r_out;
  assign o_err         = r_err;

  // Storage needs no reset: it is only observable through a non-empty head.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_wr;
  end

  // Pointers and occupancy; power-of-two depth makes the wrap implicit.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // In-flight credits; a response with nothing in flight flags a sticky error.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_out <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_pop && !i_rsp_vld) begin
        r_out <= r_out + OUT_W'(1);
      end else if (!w_pop && i_rsp_vld) begin
        if (r_out != '0) r_out <= r_out - OUT_W'(1);
        else             r_err <= 1'b1;
      end
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (!arst_n)
    r_occ <= OCC_W'(DEPTH));
  a_out_bound: assert property (@(posedge clk) disable iff (!arst_n)
    r_out <= OUT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_h_cmd_queue.sv
// Randomised and directed bench for h_cmd_queue against a queue-based model.
module tb_h_cmd_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic           i_cmd_vld = 1'b0;
  h_pkg::opcode_t i_cmd_opcode = '0;
  h_pkg::k_t      i_cmd_k = '0;
  h_pkg::v_t      i_cmd_v = '0;
  logic           o_cmd_rdy;
  logic           o_cmd_vld_w;
  h_pkg::opcode_t o_cmd_opcode_w;
  h_pkg::k_t      o_cmd_k_w;
  h_pkg::v_t      o_cmd_v_w;
  logic           i_cmd_rdy_w = 1'b0;
  logic           i_rsp_vld = 1'b0;
  logic [2:0]     o_occupancy;
  logic [1:0]     o_outstanding;
  logic           o_err;

  h_cmd_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .arst_n(arst_n),
    .i_cmd_vld(i_cmd_vld), .i_cmd_opcode(i_cmd_opcode), .i_cmd_k(i_cmd_k), .i_cmd_v(i_cmd_v),
    .o_cmd_rdy(o_cmd_rdy), .o_cmd_vld_w(o_cmd_vld_w), .o_cmd_opcode_w(o_cmd_opcode_w),
    .o_cmd_k_w(o_cmd_k_w), .o_cmd_v_w(o_cmd_v_w), .i_cmd_rdy_w(i_cmd_rdy_w),
    .i_rsp_vld(i_rsp_vld), .o_occupancy(o_occupancy), .o_outstanding(o_outstanding),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: a plain queue of pending commands plus a credit count.
  h_pkg::cmd_t q[$];
  int          m_out = 0;
  bit          m_err = 1'b0;
  bit          m_last_pop = 1'b0;
  h_pkg::k_t   dut_iss[$];

  function automatic bit m_rdy();
    return q.size() != DEPTH;
  endfunction

  function automatic bit m_vld();
    return (q.size() != 0) && (m_out < MAXO);
  endfunction

  function automatic h_pkg::cmd_t m_head();
    h_pkg::cmd_t z;
    z = '0;
    if (q.size() != 0) z = q[0];
    return z;
  endfunction

  task automatic model_reset();
    q.delete();
    m_out = 0;
    m_err = 1'b0;
    m_last_pop = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (arst_n && chk_en) begin
      h_pkg::cmd_t hd;
      hd = m_head();
      check("rdy", 32'(o_cmd_rdy), 32'(m_rdy()));
      check("vld", 32'(o_cmd_vld_w), 32'(m_vld()));
      check("payload", 32'({o_cmd_opcode_w, o_cmd_k_w, o_cmd_v_w}), 32'(hd));
      check("occ", 32'(o_occupancy), 32'(q.size()));
      check("out", 32'(o_outstanding), 32'(m_out));
      check("err", 32'(o_err), 32'(m_err));
    end
  end

  // One clock of stimulus; inputs change just after the rising edge.
  task automatic cycle(input bit vld, input h_pkg::opcode_t op, input h_pkg::k_t k,
                       input h_pkg::v_t v, input bit rdyw, input bit rsp);
    bit push, pop;
    i_cmd_vld = vld; i_cmd_opcode = op; i_cmd_k = k; i_cmd_v = v;
    i_cmd_rdy_w = rdyw; i_rsp_vld = rsp;
    if (o_cmd_vld_w && rdyw) dut_iss.push_back(o_cmd_k_w);
    push = vld && m_rdy();
    pop  = m_vld() && rdyw;
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{opcode: op, k: k, v: v});
    if (pop && !rsp) m_out++;
    else if (rsp && !pop) begin
      if (m_out > 0) m_out--;
      else m_err = 1'b1;
    end
    m_last_pop = pop;
  endtask

  task automatic idle(input bit rdyw, input bit rsp);
    cycle(1'b0, h_pkg::OP_NOP, 8'h00, 16'h0000, rdyw, rsp);
  endtask

  task automatic push(input h_pkg::k_t k, input bit rdyw);
    cycle(1'b1, h_pkg::OP_LOOKUP, k, 16'(k) * 16'd3, rdyw, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0 && m_out == 0) break;
      idle(1'b1, m_out > 0);
    end
    check("drain_done", 32'(q.size() + m_out), 32'd0);
  endtask

  initial begin
    int base;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 32'(o_cmd_rdy), 32'd1);
    check("rst_vld", 32'(o_cmd_vld_w), 32'd0);
    check("rst_k", 32'(o_cmd_k_w), 32'd0);
    check("rst_occ", 32'(o_occupancy), 32'd0);
    check("rst_out", 32'(o_outstanding), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    arst_n = 1'b1;
    chk_en = 1'b1;

    // Fill and drain.
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b0);
    check("fill_rdy", 32'(o_cmd_rdy), 32'd0);
    check("fill_occ", 32'(o_occupancy), 32'd4);
    for (int i = 0; i < 6; i++) idle(1'b1, m_last_pop);
    check("drain_occ", 32'(o_occupancy), 32'd0);
    check("drain_cnt", 32'(dut_iss.size()), 32'd4);
    for (int i = 0; i < 4 && i < dut_iss.size(); i++)
      check("drain_order", 32'(dut_iss[i]), 32'(i + 1));
    drain();

    // Backpressure hold.
    cycle(1'b1, h_pkg::OP_INSERT, 8'h05, 16'h000A, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0, 1'b0);
      check("bp_vld", 32'(o_cmd_vld_w), 32'd1);
      check("bp_op", 32'(o_cmd_opcode_w), 32'(h_pkg::OP_INSERT));
      check("bp_k", 32'(o_cmd_k_w), 32'h5);
      check("bp_v", 32'(o_cmd_v_w), 32'hA);
    end
    base = dut_iss.size();
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check("bp_issues", 32'(dut_iss.size() - base), 32'd1);
    drain();

    // Credit limit.
    for (int i = 0; i < 3; i++) push(8'(8'h21 + i), 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
    check("cred_out", 32'(o_outstanding), 32'd2);
    check("cred_vld", 32'(o_cmd_vld_w), 32'd0);
    check("cred_occ", 32'(o_occupancy), 32'd1);
    idle(1'b1, 1'b1);
    check("cred_free_vld", 32'(o_cmd_vld_w), 32'd1);
    idle(1'b1, 1'b0);
    check("cred_out2", 32'(o_outstanding), 32'd2);
    check("cred_occ0", 32'(o_occupancy), 32'd0);
    drain();

    // Simultaneous events and pointer wrap.
    push(8'h31, 1'b0);
    push(8'h32, 1'b0);
    push(8'h33, 1'b1);
    check("sim_occ", 32'(o_occupancy), 32'd2);
    idle(1'b1, 1'b1);
    check("sim_out", 32'(o_outstanding), 32'd1);
    drain();
    base = dut_iss.size();
    for (int i = 0; i < 10; i++) cycle(1'b1, h_pkg::OP_DELETE, 8'(8'h40 + i), 16'(i), 1'b1, m_out > 0);
    drain();
    check("wrap_cnt", 32'(dut_iss.size() - base), 32'd10);
    for (int i = 0; i < 10 && base + i < dut_iss.size(); i++)
      check("wrap_order", 32'(dut_iss[base + i]), 32'(8'h40 + i));

    // Spurious response.
    idle(1'b0, 1'b1);
    check("spur_err", 32'(o_err), 32'd1);
    check("spur_out", 32'(o_outstanding), 32'd0);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);
    check("spur_sticky", 32'(o_err), 32'd1);

    // Reset mid-operation.
    for (int i = 0; i < 3; i++) push(8'(8'h51 + i), 1'b0);
    push(8'h54, 1'b1);
    push(8'h55, 1'b1);
    idle(1'b0, 1'b0);
    check("pre_rst_occ", 32'(o_occupancy), 32'd3);
    check("pre_rst_out", 32'(o_outstanding), 32'd2);
    #3;
    chk_en = 1'b0;
    arst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(o_cmd_vld_w), 32'd0);
    check("mid_rst_rdy", 32'(o_cmd_rdy), 32'd1);
    check("mid_rst_occ", 32'(o_occupancy), 32'd0);
    check("mid_rst_out", 32'(o_outstanding), 32'd0);
    check("mid_rst_err", 32'(o_err), 32'd0);
    model_reset();
    i_cmd_vld = 1'b0; i_cmd_rdy_w = 1'b0; i_rsp_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    chk_en = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      bit rv, rr, rs;
      rv = $urandom_range(0, 99) < 60;
      rr = $urandom_range(0, 99) < 70;
      rs = (m_out > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
      cycle(rv, h_pkg::opcode_t'($urandom_range(0, 3)), h_pkg::k_t'($urandom),
            h_pkg::v_t'($urandom), rr, rs);
    end
    drain();

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
